// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift_right_sequencer controller and its shifter.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic TYPE_LOGICAL = 1'b0;
  localparam logic TYPE_ARITH   = 1'b1;

  // Bits to shift this cycle: the remaining amount, capped at the per-cycle step.
  function automatic int unsigned step_amt(input int unsigned rem, input int unsigned step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/SHIFT_RIGHT.sv
// Combinational right shifter: zero fill (TYPE_LOGICAL) or sign fill (TYPE_ARITH).
module SHIFT_RIGHT
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         TYPE,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Y
);

  always_comb begin
    if (TYPE == TYPE_ARITH) Y = $unsigned($signed(A) >>> B);
    else                    Y = A >> B;
  end

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle right-shift controller driving a narrow SHIFT_RIGHT at most STEP bits per cycle.
// Optional abort input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_right_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         shift_type,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic [1:0]   dbg_state
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start while ready=0 is dropped, nothing is queued.

  localparam int RW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [N-1:0]   acc_q;
  logic           typ_q;
  logic [RW-1:0]  rem_q;
  logic [RW-1:0]  b_sat;
  logic [RW-1:0]  stp;
  logic [RW-1:0]  rem_next;
  logic [N-1:0]   shifted;
  logic           abort_w;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Saturate against the full-width amount before narrowing to the counter width.
  assign b_sat    = (32'(b) >= N) ? RW'(N) : RW'(b);
  assign stp      = RW'(step_amt(32'(rem_q), 32'(STEP)));
  assign rem_next = rem_q - stp;

  SHIFT_RIGHT #(.N(N)) u_shift (
    .TYPE (typ_q),
    .A    (acc_q),
    .B    (N'(stp)),
    .Y    (shifted)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (b_sat == '0) ? DONE : RUN;
      RUN: begin
        if (abort_w)              state_d = IDLE;
        else if (rem_next == '0)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      typ_q   <= TYPE_LOGICAL;
      rem_q   <= '0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= a;
            typ_q <= shift_type;
            rem_q <= b_sat;
            if (b_sat == '0) out <= a;
          end
        end
        RUN: begin
          if (!abort_w) begin
            acc_q <= shifted;
            rem_q <= rem_next;
            if (rem_next == '0) out <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Self-checking bench for shift_right_sequencer (N=8, STEP=2): vector table, hand sequences, random vs model.
module tb_shift_right_sequencer;

  localparam int N    = 8;
  localparam int STEP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         shift_type;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic [1:0]   dbg_state;
`ifdef SHIFT_SEQ_ABORT_EN
  logic         abort;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [N-1:0] exp_q[$];

  shift_right_sequencer #(.N(N), .STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_type (shift_type),
    .a          (a),
    .b          (b),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: bit-at-a-time shifting of the saturated amount; latency counts the capture edge.
  function automatic logic [N-1:0] ref_shift(input logic t, input logic [N-1:0] x, input logic [N-1:0] amt_in);
    logic [N-1:0] r;
    int amt;
    amt = (int'(amt_in) >= N) ? N : int'(amt_in);
    r = x;
    for (int i = 0; i < amt; i++) r = {(t ? r[N-1] : 1'b0), r[N-1:1]};
    return r;
  endfunction

  function automatic int ref_lat(input logic [N-1:0] amt_in);
    int amt;
    amt = (int'(amt_in) >= N) ? N : int'(amt_in);
    return (amt + STEP - 1) / STEP + 1;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver: issue one request from a negedge, count edges to done, return result and latency.
  task automatic run_req(input logic t, input logic [N-1:0] av, input logic [N-1:0] bv,
                         output logic [N-1:0] got, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    start = 1'b1; shift_type = t; a = av; b = bv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    got = out;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: done not seen after %0d edges", lat);
    end
  endtask

  // Scoreboard-backed transaction: model pushes, completion pops and compares.
  task automatic txn(input string name, input logic t, input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N-1:0] got, exp;
    int lat;
    exp_q.push_back(ref_shift(t, av, bv));
    run_req(t, av, bv, got, lat);
    exp = exp_q.pop_front();
    check({name, "_out"}, int'(got), int'(exp));
    check({name, "_lat"}, lat, ref_lat(bv));
    @(negedge clk);
    check({name, "_done_1cyc"}, int'(done), 0);
    check({name, "_ready_after"}, int'(ready), 1);
    check({name, "_out_held"}, int'(out), int'(exp));
  endtask

  typedef struct {
    logic         t;
    logic [N-1:0] av;
    logic [N-1:0] bv;
    logic [N-1:0] exp_out;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] got;
    int lat;
    int seen_done;
    logic t;
    logic [N-1:0] av, bv;

    vecs[0] = '{1'b0, 8'h0B, 8'h01, 8'h05, 2};
    vecs[1] = '{1'b0, 8'h2B, 8'h03, 8'h05, 3};
    vecs[2] = '{1'b1, 8'h45, 8'h05, 8'h02, 4};
    vecs[3] = '{1'b1, 8'h8B, 8'h01, 8'hC5, 2};
    vecs[4] = '{1'b0, 8'h8B, 8'h25, 8'h00, 5};
    vecs[5] = '{1'b1, 8'h8B, 8'h25, 8'hFF, 5};
    vecs[6] = '{1'b0, 8'h5A, 8'h00, 8'h5A, 1};
    vecs[7] = '{1'b1, 8'h96, 8'h08, 8'hFF, 5};

    shift_type = 1'b0; a = '0; b = '0;
    do_reset();
    check("rst_out", int'(out), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(ready), 1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_req(vecs[i].t, vecs[i].av, vecs[i].bv, got, lat);
      check($sformatf("vec%0d_out", i), int'(got), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      @(negedge clk);
      check($sformatf("vec%0d_done_drop", i), int'(done), 0);
    end

    // Second start during RUN is ignored
    @(negedge clk);
    start = 1'b1; shift_type = 1'b0; a = 8'h2B; b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    check("ign_busy", int'(busy), 1);
    a = 8'hFF; b = 8'h00; shift_type = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    check("ign_out", int'(out), 8'h05);
    check("ign_lat", lat, 3);
    @(negedge clk);
    check("ign_no_second_run", int'(busy), 0);

    // start asserted in the DONE cycle is ignored
    @(negedge clk);
    start = 1'b1; shift_type = 1'b0; a = 8'h10; b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("dn_done", int'(done), 1);
    a = 8'hEE; b = 8'h04;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("dn_ignored_ready", int'(ready), 1);
    check("dn_ignored_out", int'(out), 8'h10);

    // rst mid-RUN discards the request
    @(negedge clk);
    start = 1'b1; shift_type = 1'b1; a = 8'hC3; b = 8'h07;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out", int'(out), 0);
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("mid_rst_no_done", seen_done, 0);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort on the second RUN cycle leaves out at the prior result
    run_req(1'b1, 8'h8B, 8'h01, got, lat);
    check("ab_prior", int'(got), 8'hC5);
    @(negedge clk);
    start = 1'b1; shift_type = 1'b1; a = 8'h80; b = 8'h07;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("ab_ready", int'(ready), 1);
    check("ab_busy", int'(busy), 0);
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("ab_no_done", seen_done, 0);
    check("ab_out_kept", int'(out), 8'hC5);
    // abort coinciding with start in IDLE does not block acceptance
    start = 1'b1; abort = 1'b1; shift_type = 1'b0; a = 8'h40; b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("ab_idle_accept", int'(busy), 1);
    lat = 1;
    while (!done && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    check("ab_idle_out", int'(out), 8'h10);
`endif

    // Randomized requests against the reference model
    for (int k = 0; k < 40; k++) begin
      t  = 1'($urandom_range(0, 1));
      av = 8'($urandom);
      bv = (k % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      txn($sformatf("rnd%0d", k), t, av, bv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
